// File: rtl/uaz8_data_bus_arbiter_if.sv
// rtl/uaz8_data_bus_arbiter_if.sv - MicroUAZ8 data bus arbiter interface
//
// Purpose: bundles the two requester ports, the shared external bus and the
// arbiter responses into one interface.
// Signals:
//   i_Req0/1, i_We0/1, i_Addr0/1, i_Wdata0/1 : requester side (1 = write)
//   o_Gnt0/1, o_Done0/1, o_Rdata              : arbiter responses
//   i_Dato_Bus                                : data returned from the bus
//   o_Addres_Data_Bus, o_DataOut_Bus, RW      : bus drive (RW 1 = read)
// Modports:
//   slave  - the arbiter itself
//   master - requesters and bus model driving the arbiter

interface uaz8_data_bus_arbiter_if;
  logic       i_Req0;
  logic       i_Req1;
  logic       i_We0;
  logic       i_We1;
  logic [7:0] i_Addr0;
  logic [7:0] i_Addr1;
  logic [7:0] i_Wdata0;
  logic [7:0] i_Wdata1;
  logic       o_Gnt0;
  logic       o_Gnt1;
  logic       o_Done0;
  logic       o_Done1;
  logic [7:0] o_Rdata;
  logic [7:0] i_Dato_Bus;
  logic [7:0] o_Addres_Data_Bus;
  logic [7:0] o_DataOut_Bus;
  logic       RW;

  modport slave (
    input  i_Req0, i_Req1, i_We0, i_We1, i_Addr0, i_Addr1,
    input  i_Wdata0, i_Wdata1, i_Dato_Bus,
    output o_Gnt0, o_Gnt1, o_Done0, o_Done1, o_Rdata,
    output o_Addres_Data_Bus, o_DataOut_Bus, RW
  );

  modport master (
    output i_Req0, i_Req1, i_We0, i_We1, i_Addr0, i_Addr1,
    output i_Wdata0, i_Wdata1, i_Dato_Bus,
    input  o_Gnt0, o_Gnt1, o_Done0, o_Done1, o_Rdata,
    input  o_Addres_Data_Bus, o_DataOut_Bus, RW
  );
endinterface

// File: rtl/uaz8_data_bus_arbiter.sv
// rtl/uaz8_data_bus_arbiter.sv - two-requester arbiter and access sequencer for the MicroUAZ8 data bus
//
// Purpose: grants the external data bus to one of two requesters, drives the
// latched address/data/direction for WAIT_STATES+1 ACCESS cycles, captures
// read data on the last ACCESS cycle and pulses the winner's done for one cycle.
// Ports:
//   Clk  - system clock, rising edge
//   Rst  - synchronous active-high reset
//   bus  - uaz8_data_bus_arbiter_if.slave (requesters, responses, bus drive)
// Parameters:
//   WAIT_STATES - extra ACCESS cycles per transfer, 0..15
// Configuration:
//   UAZ8_ARB_ROUND_ROBIN_EN - defined: ties go to the requester that was not
//   granted last; undefined: requester 0 always wins ties.

module uaz8_data_bus_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input logic                      Clk,
  input logic                      Rst,
  uaz8_data_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_grant_q, last_grant_d;
  logic       win_q, win_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic       rw_q, rw_d;
  logic       pick;

  // Winner of an arbitration in IDLE: 0 = requester 0, 1 = requester 1.
  always_comb begin
`ifdef UAZ8_ARB_ROUND_ROBIN_EN
    pick = (bus.i_Req0 && bus.i_Req1) ? ~last_grant_q : bus.i_Req1;
`else
    pick = ~bus.i_Req0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata_d      = rdata_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    rw_d         = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.i_Req0 || bus.i_Req1) begin
          win_d        = pick;
          last_grant_d = pick;
          addr_d       = pick ? bus.i_Addr1  : bus.i_Addr0;
          dout_d       = pick ? bus.i_Wdata1 : bus.i_Wdata0;
          rw_d         = pick ? ~bus.i_We1   : ~bus.i_We0;
          gnt0_d       = ~pick;
          gnt1_d       = pick;
          cnt_d        = 4'd0;
          state_d      = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // Bus drive and grant stay frozen; requester inputs are ignored here.
        gnt0_d = gnt0_q;
        gnt1_d = gnt1_q;
        rw_d   = rw_q;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          rw_d    = 1'b1;
          done0_d = ~win_q;
          done1_d = win_q;
          // rw_q still holds the direction of the transfer being finished.
          if (rw_q) begin
            rdata_d = bus.i_Dato_Bus;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata_q      <= 8'h00;
      addr_q       <= 8'h00;
      dout_q       <= 8'h00;
      rw_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      rdata_q      <= rdata_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      rw_q         <= rw_d;
    end
  end

  assign bus.o_Gnt0            = gnt0_q;
  assign bus.o_Gnt1            = gnt1_q;
  assign bus.o_Done0           = done0_q;
  assign bus.o_Done1           = done1_q;
  assign bus.o_Rdata           = rdata_q;
  assign bus.o_Addres_Data_Bus = addr_q;
  assign bus.o_DataOut_Bus     = dout_q;
  assign bus.RW                = rw_q;

endmodule

// File: tb/tb_uaz8_data_bus_arbiter.sv
// tb/tb_uaz8_data_bus_arbiter.sv - self-checking bench for uaz8_data_bus_arbiter
//
// Three arbiters (WAIT_STATES = 1, 3, 0) share one stimulus stream. Each has a
// transaction-timeline model checked every cycle, plus directed literal checks.

module tb_uaz8_data_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wd0, wd1, dato;

  logic       gnt0_w  [3];
  logic       gnt1_w  [3];
  logic       done0_w [3];
  logic       done1_w [3];
  logic       rw_w    [3];
  logic [7:0] rdata_w [3];
  logic [7:0] addr_w  [3];
  logic [7:0] dout_w  [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 3 : 0;

    uaz8_data_bus_arbiter_if bus_if ();

    uaz8_data_bus_arbiter #(.WAIT_STATES(WS)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus_if)
    );

    assign bus_if.i_Req0     = req0;
    assign bus_if.i_Req1     = req1;
    assign bus_if.i_We0      = we0;
    assign bus_if.i_We1      = we1;
    assign bus_if.i_Addr0    = addr0;
    assign bus_if.i_Addr1    = addr1;
    assign bus_if.i_Wdata0   = wd0;
    assign bus_if.i_Wdata1   = wd1;
    assign bus_if.i_Dato_Bus = dato;

    assign gnt0_w[g]  = bus_if.o_Gnt0;
    assign gnt1_w[g]  = bus_if.o_Gnt1;
    assign done0_w[g] = bus_if.o_Done0;
    assign done1_w[g] = bus_if.o_Done1;
    assign rw_w[g]    = bus_if.RW;
    assign rdata_w[g] = bus_if.o_Rdata;
    assign addr_w[g]  = bus_if.o_Addres_Data_Bus;
    assign dout_w[g]  = bus_if.o_DataOut_Bus;

    // Model: a transfer is a timeline of offsets from the IDLE sample cycle
    // (offset 0). ACCESS = offsets 1..WS+1, DONE = WS+2, idle again at WS+3.
    bit         busy;
    int         age;
    bit         win, we_l, lg;
    logic [7:0] a_l, d_l, m_rdata;

    always @(posedge clk) begin
      if (rst) begin
        busy = 0; age = 0; lg = 1; win = 0; we_l = 0;
        a_l = 8'h00; d_l = 8'h00; m_rdata = 8'h00;
      end else if (busy) begin
        if (age == WS + 1 && !we_l) m_rdata = dato;
        age++;
        if (age == WS + 3) busy = 0;
      end else if (req0 || req1) begin
        if (req0 && req1) begin
`ifdef UAZ8_ARB_ROUND_ROBIN_EN
          win = !lg;
`else
          win = 0;
`endif
        end else begin
          win = req1;
        end
        lg   = win;
        a_l  = win ? addr1 : addr0;
        d_l  = win ? wd1 : wd0;
        we_l = win ? we1 : we0;
        busy = 1;
        age  = 1;
      end
    end

    always @(negedge clk) begin
      bit in_acc, in_done;
      logic [28:0] exp_v, got_v;
      in_acc  = busy && age >= 1 && age <= WS + 1;
      in_done = busy && age == WS + 2;
      exp_v = {in_acc && !win, in_acc && win, in_done && !win, in_done && win,
               in_acc ? !we_l : 1'b1, m_rdata, a_l, d_l};
      got_v = {gnt0_w[g], gnt1_w[g], done0_w[g], done1_w[g], rw_w[g],
               rdata_w[g], addr_w[g], dout_w[g]};
      n_checks++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL model_ws%0d at %0t: got %h expected %h", WS, $time, got_v, exp_v);
    end
  end

  initial begin
    int   found;
    int   gcyc [4];
    int   gid  [4];
    int   exp_id [4];
    logic prev;

    rst = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    addr0 = 8'h11; addr1 = 8'h22; wd0 = 8'h33; wd1 = 8'h44; dato = 8'h00;

    // Reset values with both requests pending, then first grant to requester 0.
    repeat (2) @(negedge clk);
    chk("rst_gnt0", gnt0_w[0], 0);
    chk("rst_gnt1", gnt1_w[0], 0);
    chk("rst_done", {done0_w[0], done1_w[0]}, 0);
    chk("rst_rdata", rdata_w[0], 8'h00);
    chk("rst_addr", addr_w[0], 8'h00);
    chk("rst_dout", dout_w[0], 8'h00);
    chk("rst_rw", rw_w[0], 1);
    rst = 0;
    @(negedge clk);
    chk("first_gnt0", gnt0_w[0], 1);
    chk("first_gnt1", gnt1_w[0], 0);
    chk("first_addr", addr_w[0], 8'h11);
    req0 = 0; req1 = 0;
    repeat (8) @(negedge clk);

    // Single write from requester 1.
    we1 = 1; addr1 = 8'h3C; wd1 = 8'hA5; req1 = 1;
    @(negedge clk); req1 = 0;
    chk("wr_c1_gnt1", gnt1_w[0], 1);
    chk("wr_c1_bus", {addr_w[0], dout_w[0], 7'd0, rw_w[0]}, {8'h3C, 8'hA5, 8'h00});
    @(negedge clk);
    chk("wr_c2_gnt1", gnt1_w[0], 1);
    chk("wr_c2_rw", rw_w[0], 0);
    @(negedge clk);
    chk("wr_c3_done1", done1_w[0], 1);
    chk("wr_c3_gnt1", gnt1_w[0], 0);
    chk("wr_c3_rw", rw_w[0], 1);
    chk("wr_c3_addr", addr_w[0], 8'h3C);
    repeat (6) @(negedge clk);

    // Single read from requester 0, then a write that must leave o_Rdata alone.
    we0 = 0; addr0 = 8'h10; dato = 8'h5A; req0 = 1;
    @(negedge clk); req0 = 0;
    chk("rd_c1_gnt0", gnt0_w[0], 1);
    chk("rd_c1_addr", addr_w[0], 8'h10);
    chk("rd_c1_rw", rw_w[0], 1);
    repeat (2) @(negedge clk);
    chk("rd_c3_done0", done0_w[0], 1);
    chk("rd_c3_rdata", rdata_w[0], 8'h5A);
    repeat (6) @(negedge clk);
    we0 = 1; addr0 = 8'h20; wd0 = 8'h77; dato = 8'hFF; req0 = 1;
    @(negedge clk); req0 = 0;
    repeat (2) @(negedge clk);
    chk("wr2_done0", done0_w[0], 1);
    chk("wr2_rdata_kept", rdata_w[0], 8'h5A);
    repeat (6) @(negedge clk);

    // Reset in the 2nd ACCESS cycle of the WAIT_STATES=3 arbiter.
    we0 = 0; addr0 = 8'h44; dato = 8'hC3; req0 = 1;
    @(negedge clk); req0 = 0;
    @(negedge clk);
    chk("mid_c2_gnt0", gnt0_w[1], 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_gnt0", gnt0_w[1], 0);
    chk("mid_rw", rw_w[1], 1);
    chk("mid_rdata", rdata_w[1], 8'h00);
    for (int k = 0; k < 6; k++) begin
      chk("mid_no_done", {done0_w[1], done1_w[1]}, 0);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // Tie: both requests held for four transfers on the WAIT_STATES=1 arbiter.
`ifdef UAZ8_ARB_ROUND_ROBIN_EN
    exp_id = '{0, 1, 0, 1};
`else
    exp_id = '{0, 0, 0, 0};
`endif
    we0 = 0; we1 = 0; req0 = 1; req1 = 1;
    found = 0; prev = 0;
    for (int c = 0; c < 30 && found < 4; c++) begin
      @(negedge clk);
      if ((gnt0_w[0] || gnt1_w[0]) && !prev) begin
        gcyc[found] = c;
        gid[found]  = gnt1_w[0] ? 1 : 0;
        found++;
      end
      prev = gnt0_w[0] || gnt1_w[0];
    end
    req0 = 0; req1 = 0;
    chk("tie_count", found, 4);
    if (found == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("tie_order%0d", i), gid[i], exp_id[i]);
      for (int i = 1; i < 4; i++) chk($sformatf("tie_gap%0d", i), gcyc[i] - gcyc[i-1], 4);
    end
    repeat (10) @(negedge clk);

    // Zero wait states with requester 0 held high.
    we0 = 0; req0 = 1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("zws_gnt_c%0d", k), gnt0_w[2], (k == 1 || k == 4 || k == 7));
      chk($sformatf("zws_done_c%0d", k), done0_w[2], (k == 2 || k == 5 || k == 8));
      chk($sformatf("zws_overlap_c%0d", k), gnt0_w[2] && done0_w[2], 0);
    end
    req0 = 0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uaz8_data_bus_arbiter.md
# uaz8_data_bus_arbiter

Two-requester arbiter and access sequencer for the MicroUAZ8 external data bus (address, data-out, RW, data-in). It sits between the bus port of the core's output-bus controller (requester 0) and an auxiliary master such as a DMA or debug port (requester 1). It grants one requester at a time and drives the shared bus for a fixed number of wait states. It returns read data with a one-cycle done pulse.

## Interface
- `WAIT_STATES`, default 1: extra ACCESS cycles per transfer; legal range 0–15.
- `Clk` in 1: system clock; all logic on its rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `i_Req0` / `i_Req1` in 1 each: level request from requester 0 / requester 1.
- `i_We0` / `i_We1` in 1 each: 1 = write, 0 = read.
- `i_Addr0` / `i_Addr1` in 8 each: transfer address.
- `i_Wdata0` / `i_Wdata1` in 8 each: write data.
- `o_Gnt0` / `o_Gnt1` out 1 each: high while that requester owns the bus (ACCESS state).
- `o_Done0` / `o_Done1` out 1 each: one-cycle completion pulse.
- `o_Rdata` out 8: read data captured for the last completed transfer.
- `i_Dato_Bus` in 8: data returned from the bus.
- `o_Addres_Data_Bus` out 8: bus address.
- `o_DataOut_Bus` out 8: bus write data.
- `RW` out 1: bus direction; 1 = read, 0 = write.

## Operation
- All outputs are registered. Reset values:
  - `o_Gnt*` = 0, `o_Done*` = 0.
  - `o_Rdata` = 8'h00.
  - `o_Addres_Data_Bus` = 8'h00, `o_DataOut_Bus` = 8'h00.
  - `RW` = 1.
  - State = IDLE, wait counter = 0, `last_grant` = 1.
- The FSM has three states:
  - **IDLE**
    - No request: stay in IDLE; bus outputs hold address and data, `RW` = 1.
    - Any request: choose a winner. Latch that requester's address, write data and `~We` into the bus outputs. Set its `o_Gnt`, set `last_grant` = winner, clear the counter, go to ACCESS.
  - **ACCESS**
    - The counter increments each cycle. The state lasts exactly `WAIT_STATES`+1 cycles.
    - Bus outputs are held constant; the requester's inputs are not re-sampled.
    - On the last cycle: capture `i_Dato_Bus` into `o_Rdata` if the transfer is a read. For a write, `o_Rdata` is unchanged. Go to DONE.
  - **DONE**
    - Gnt is low; the winner's `o_Done` is high for exactly this cycle.
    - `RW` returns to 1; address and data hold.
    - Next state is always IDLE.
- Arbitration happens in IDLE only; there is no preemption.
- The requester may drop `i_Req` any time after grant. A request still high in the IDLE cycle after DONE is a new transfer.
- A request asserted while the other requester is being served waits. It is evaluated in the next IDLE cycle.
- `o_Gnt0` and `o_Gnt1` are never high together; `o_Done0` and `o_Done1` are never high together.
- `Rst` asserted mid-transfer: return to IDLE on that edge with reset values; no done pulse is produced for the aborted transfer.

## Timing
- Request sampled in IDLE at cycle 0:
  - Gnt and bus outputs valid from cycle 1 through cycle `WAIT_STATES`+1.
  - Done is high in cycle `WAIT_STATES`+2.
  - The earliest next grant is in cycle `WAIT_STATES`+4.
- Read data: `i_Dato_Bus` is sampled at the rising edge ending cycle `WAIT_STATES`+1. It is valid on `o_Rdata` from cycle `WAIT_STATES`+2 (coincident with done) until the next read completes.
- Throughput per back-to-back transfer: `WAIT_STATES`+3 cycles.
- With `WAIT_STATES` = 0: grant at cycle 1, done at cycle 2, next grant at cycle 4.

## Configuration
- Macro: `UAZ8_ARB_ROUND_ROBIN_EN`.
- Defined: on simultaneous requests in IDLE, the grant goes to the requester that is not `last_grant`. After reset (`last_grant` = 1) requester 0 wins the first tie. A single request is always granted.
- Undefined: fixed priority; requester 0 always wins ties. `last_grant` still updates but does not affect the choice.

## Test plan
- **Reset values:** `WAIT_STATES`=1; hold `Rst`=1 for 2 cycles with both requests high → every output at its reset value; first grant appears 2 cycles after `Rst` falls (IDLE, then ACCESS) to requester 0.
- **Single write:** `Req1` with `We1`=1, `Addr1`=8'h3C, `Wdata1`=8'hA5 → bus shows 3C/A5 with `RW`=0 for 2 cycles while `o_Gnt1`=1; `o_Done1` pulses in cycle 3; `RW`=1 in cycle 3.
- **Single read:** `Req0` read, `Addr0`=8'h10, `i_Dato_Bus`=8'h5A during ACCESS → `o_Rdata`=8'h5A with `o_Done0` in cycle 3; `o_Rdata` unchanged after a subsequent write.
- **Tie, round robin:** both requests held high for 4 transfers with the macro defined → grant order 0,1,0,1, each transfer 4 cycles apart. With the macro undefined → order 0,0,0,0.
- **Reset mid-ACCESS:** `WAIT_STATES`=3; assert `Rst` in the 2nd ACCESS cycle → next cycle is IDLE, no `o_Done*` pulse, `RW`=1, `o_Rdata` = 8'h00.
- **Zero wait states:** `WAIT_STATES`=0, `Req0` held high → grants in cycles 1, 4, 7; done pulses in cycles 2, 5, 8; gnt and done never overlap.
